input_debounce: RTL and testbench
=================================

# input_debounce

Switch/button conditioner sitting directly upstream of the memory-mapped input device and the interrupt controller in the SoC top level. It synchronises the six raw board inputs (`{subset_in, rdy}`) and the raw external-interrupt switch into `clk`, debounces each bit independently with a per-bit counter, and presents glitch-free stable levels on `di`. It also emits a one-cycle pulse on a debounced rising edge of the interrupt switch, suitable for `INT[0]` of the interrupt controller, and a one-cycle strobe whenever any data bit changes.

## Interface
- `DB_COUNT`, default 50000: consecutive cycles a synchronised bit must disagree with its stable value before the stable value flips; legal range 1..2^CNT_W.
- `CNT_W`, default 16: width of each per-bit debounce counter; must hold `DB_COUNT-1`.
- `clk`  in  1  system clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `raw_in`  in  6  asynchronous switch inputs, bit 0 = `rdy`.
- `raw_int`  in  1  asynchronous external-interrupt switch.
- `di`  out  6  debounced stable level of `raw_in`; feeds the input device.
- `int_lvl`  out  1  debounced stable level of `raw_int`.
- `int_pulse`  out  1  one-cycle pulse on debounced 0→1 of `int_lvl`.
- `chg`  out  1  one-cycle strobe when any bit of `di` changed.

## Operation
- Seven identical channels (6 data + 1 interrupt); each has: 2-flop synchroniser `s1→s2`, stable register `st`, counter `cnt[CNT_W-1:0]`.
- Per channel, every edge (when not in reset):
  - `s2 == st`: `cnt <= 0`.
  - `s2 != st` and `cnt == DB_COUNT-1`: `st <= s2`, `cnt <= 0`.
  - `s2 != st` otherwise: `cnt <= cnt + 1`.
- Any single cycle of `s2 == st` during counting restarts the count from 0 (glitch rejection); no partial credit.
- Counter never exceeds `DB_COUNT-1`; no wrap-around possible.
- `di = st[5:0]`, `int_lvl = st_int`, driven straight from registers.
- `int_pulse` is registered: high in the cycle after the edge at which `st_int` went 0→1; 1→0 transition produces no pulse.
- `chg` is registered: high in the cycle after any edge at which one or more `st[5:0]` bits flipped; simultaneous multi-bit flips give a single one-cycle strobe.
- Channels fully independent: simultaneous transitions on several bits each debounce on their own count.
- `DB_COUNT == 1`: stable follows `s2` with one edge of delay, still glitch-free with respect to metastability only.

## Timing
- Reset (`rst` high at an edge): `s1`, `s2`, `st`, `cnt` of all channels, `int_pulse`, `chg` <= 0. Outputs `di=6'b0`, `int_lvl=0`, `int_pulse=0`, `chg=0` from the first edge with `rst` high.
- Reset mid-count discards the count; inputs held high through reset are re-debounced from 0 after release (full latency applies).
- Latency: raw change first captured into `s1` at edge k; `s2` differs after edge k+1; `st` (and `di`/`int_lvl`) updates at edge k+1+DB_COUNT; `int_pulse`/`chg` high during the cycle following edge k+2+DB_COUNT... i.e. asserted at edge k+2+DB_COUNT, deasserted at k+3+DB_COUNT.
- Minimum accepted pulse width on a raw input: DB_COUNT cycles as seen at `s2`; shorter pulses produce no output change.
- No handshakes; outputs are level/pulse, consumer samples every cycle.

## Test plan
- Reset: DB_COUNT=4, `raw_in=6'h3F`, `raw_int=1` during 3 reset cycles -> `di=0`, `int_lvl=0`, `int_pulse=0`, `chg=0` through reset; after release `di=6'h3F` exactly 5 edges after first post-reset sample edge.
- Clean step: DB_COUNT=4, `raw_in` 0→`6'h01` captured at edge k -> `di=6'h01` at edge k+5, `chg` high for exactly one cycle at k+6, `int_pulse` never high.
- Glitch rejection: DB_COUNT=4, `raw_in[3]` high for 3 cycles, low 1, high 3 -> `di` stays 0, `chg` never asserts; then hold high 4 cycles -> `di=6'h08`.
- Interrupt edge: DB_COUNT=4, `raw_int` 0→1 held -> `int_lvl=1` at k+5, `int_pulse` high one cycle at k+6; later 1→0 held -> `int_lvl=0`, no `int_pulse`.
- Simultaneous/independent: DB_COUNT=4, `raw_in` bits 1 and 4 rise same cycle, bit 2 rises 2 cycles later -> `di=6'h12` then `6'h16` two cycles apart, `chg` pulses twice.
- Reset mid-count: DB_COUNT=4, `raw_in[0]` rises, `rst` asserted 2 cycles later for 1 cycle -> `di[0]` stays 0 until 5 edges after reset release sampling.

Source files
------------

// File: rtl/input_debounce.sv
// Switch/button conditioner: 2-flop synchronisers plus independent per-bit debounce
// for six data inputs and one interrupt switch, with edge pulse and change strobe.
module input_debounce #(
    parameter int DB_COUNT = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] raw_in,
    input  logic       raw_int,
    output logic [5:0] di,
    output logic       int_lvl,
    output logic       int_pulse,
    output logic       chg
);

    localparam int             NCH     = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

    logic [NCH-1:0]   raw_all;
    logic [NCH-1:0]   s1_q, s1_d;
    logic [NCH-1:0]   s2_q, s2_d;
    logic [NCH-1:0]   st_q, st_d;
    logic [NCH-1:0]   st_prev_q, st_prev_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic             int_pulse_q, int_pulse_d;
    logic             chg_q, chg_d;

    // Channel 6 is the interrupt switch; channels 5..0 are the data bits.
    assign raw_all = {raw_int, raw_in};

    always_comb begin
        s1_d      = raw_all;
        s2_d      = s1_q;
        st_d      = st_q;
        st_prev_d = st_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != st_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    st_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // Edge detection compares the stable level against its one-cycle-old copy,
        // so both strobes land one edge after the stable register flips.
        chg_d       = |(st_q[5:0] ^ st_prev_q[5:0]);
        int_pulse_d = st_q[6] & ~st_prev_q[6];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            st_q        <= '0;
            st_prev_q   <= '0;
            int_pulse_q <= 1'b0;
            chg_q       <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            st_q        <= st_d;
            st_prev_q   <= st_prev_d;
            int_pulse_q <= int_pulse_d;
            chg_q       <= chg_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign di        = st_q[5:0];
    assign int_lvl   = st_q[6];
    assign int_pulse = int_pulse_q;
    assign chg       = chg_q;

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: vector table, directed corner sequences,
// and randomized switch activity compared against a run-length reference model.
module tb_input_debounce;

    localparam int DB = 4;
    localparam int CW = 2;

    logic       clk;
    logic       rst;
    logic [5:0] raw_in;
    logic       raw_int;
    logic [5:0] di;
    logic       int_lvl;
    logic       int_pulse;
    logic       chg;

    int n_checks = 0;
    int n_fail   = 0;

    input_debounce #(.DB_COUNT(DB), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in),
        .raw_int   (raw_int),
        .di        (di),
        .int_lvl   (int_lvl),
        .int_pulse (int_pulse),
        .chg       (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: two-stage sample pipeline, run length of disagreement per bit,
    // and the stable word one edge ago for the strobes.
    bit [6:0] m_s1, m_s2, m_st, m_st_old;
    int       m_run [7];
    bit       m_chg, m_pulse;

    task automatic model_edge();
        bit [6:0] nxt;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_st_old = '0;
            m_chg = 0; m_pulse = 0;
            for (int c = 0; c < 7; c++) m_run[c] = 0;
        end else begin
            nxt = m_st;
            for (int c = 0; c < 7; c++) begin
                if (m_s2[c] != m_st[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == DB) begin
                        nxt[c]   = m_s2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_chg    = (m_st[5:0] != m_st_old[5:0]);
            m_pulse  = m_st[6] && !m_st_old[6];
            m_st_old = m_st;
            m_st     = nxt;
            m_s2     = m_s1;
            m_s1     = {raw_int, raw_in};
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input bit r, input bit [5:0] ri, input bit rint);
        rst     = r;
        raw_in  = ri;
        raw_int = rint;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_di",        int'(di),        int'(m_st[5:0]));
        chk("model_int_lvl",   int'(int_lvl),   int'(m_st[6]));
        chk("model_int_pulse", int'(int_pulse), int'(m_pulse));
        chk("model_chg",       int'(chg),       int'(m_chg));
    endtask

    typedef struct {
        bit       r;
        bit [5:0] ri;
        bit       rint;
        bit [5:0] e_di;
        bit       e_lvl;
        bit       e_pulse;
        bit       e_chg;
    } vec_t;

    vec_t tbl [25];

    initial begin
        bit [5:0] rv;
        bit       iv;
        int       pulses;
        bit [5:0] exp_di;

        rst = 1'b1; raw_in = '0; raw_int = 1'b0;

        // Clean data step then interrupt rise/fall, one entry per edge.
        tbl[0]  = '{1, 6'h00, 0, 6'h00, 0, 0, 0};
        tbl[1]  = '{1, 6'h00, 0, 6'h00, 0, 0, 0};
        tbl[2]  = '{0, 6'h01, 0, 6'h00, 0, 0, 0};
        tbl[3]  = '{0, 6'h01, 0, 6'h00, 0, 0, 0};
        tbl[4]  = '{0, 6'h01, 0, 6'h00, 0, 0, 0};
        tbl[5]  = '{0, 6'h01, 0, 6'h00, 0, 0, 0};
        tbl[6]  = '{0, 6'h01, 0, 6'h00, 0, 0, 0};
        tbl[7]  = '{0, 6'h01, 0, 6'h01, 0, 0, 0};
        tbl[8]  = '{0, 6'h01, 0, 6'h01, 0, 0, 1};
        tbl[9]  = '{0, 6'h01, 0, 6'h01, 0, 0, 0};
        tbl[10] = '{0, 6'h01, 1, 6'h01, 0, 0, 0};
        tbl[11] = '{0, 6'h01, 1, 6'h01, 0, 0, 0};
        tbl[12] = '{0, 6'h01, 1, 6'h01, 0, 0, 0};
        tbl[13] = '{0, 6'h01, 1, 6'h01, 0, 0, 0};
        tbl[14] = '{0, 6'h01, 1, 6'h01, 0, 0, 0};
        tbl[15] = '{0, 6'h01, 1, 6'h01, 1, 0, 0};
        tbl[16] = '{0, 6'h01, 1, 6'h01, 1, 1, 0};
        tbl[17] = '{0, 6'h01, 1, 6'h01, 1, 0, 0};
        tbl[18] = '{0, 6'h01, 0, 6'h01, 1, 0, 0};
        tbl[19] = '{0, 6'h01, 0, 6'h01, 1, 0, 0};
        tbl[20] = '{0, 6'h01, 0, 6'h01, 1, 0, 0};
        tbl[21] = '{0, 6'h01, 0, 6'h01, 1, 0, 0};
        tbl[22] = '{0, 6'h01, 0, 6'h01, 1, 0, 0};
        tbl[23] = '{0, 6'h01, 0, 6'h01, 0, 0, 0};
        tbl[24] = '{0, 6'h01, 0, 6'h01, 0, 0, 0};

        for (int i = 0; i < 25; i++) begin
            tick(tbl[i].r, tbl[i].ri, tbl[i].rint);
            chk($sformatf("tbl%0d_di", i),    int'(di),        int'(tbl[i].e_di));
            chk($sformatf("tbl%0d_lvl", i),   int'(int_lvl),   int'(tbl[i].e_lvl));
            chk($sformatf("tbl%0d_pulse", i), int'(int_pulse), int'(tbl[i].e_pulse));
            chk($sformatf("tbl%0d_chg", i),   int'(chg),       int'(tbl[i].e_chg));
        end

        // Inputs held high through reset are re-debounced with full latency.
        for (int i = 0; i < 3; i++) begin
            tick(1, 6'h3F, 1);
            chk("rst_di", int'(di), 0);
            chk("rst_lvl", int'(int_lvl), 0);
            chk("rst_pulse", int'(int_pulse), 0);
            chk("rst_chg", int'(chg), 0);
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 6'h3F, 1);
            chk($sformatf("rel%0d_di", i), int'(di), (i >= 5) ? 6'h3F : 0);
            chk($sformatf("rel%0d_lvl", i), int'(int_lvl), (i >= 5) ? 1 : 0);
            chk($sformatf("rel%0d_pulse", i), int'(int_pulse), (i == 6) ? 1 : 0);
            chk($sformatf("rel%0d_chg", i), int'(chg), (i == 6) ? 1 : 0);
        end

        // Glitch rejection: 3 high, 1 low, 3 high never reaches the count.
        tick(1, 0, 0); tick(1, 0, 0);
        for (int i = 0; i < 13; i++) begin
            rv = (i < 7 && i != 3) ? 6'h08 : 6'h00;
            tick(0, rv, 0);
            chk("glitch_di", int'(di), 0);
            chk("glitch_chg", int'(chg), 0);
        end
        // Exactly DB_COUNT cycles high is accepted, then debounces back down.
        for (int i = 0; i < 12; i++) begin
            rv = (i < 4) ? 6'h08 : 6'h00;
            tick(0, rv, 0);
            chk($sformatf("minw%0d_di", i), int'(di), (i >= 5 && i <= 8) ? 6'h08 : 0);
            chk($sformatf("minw%0d_chg", i), int'(chg), (i == 6 || i == 10) ? 1 : 0);
        end

        // Independent channels: bits 1,4 at once, bit 2 two cycles later.
        tick(1, 0, 0); tick(1, 0, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            rv = 6'h12 | ((i >= 2) ? 6'h04 : 6'h00);
            tick(0, rv, 0);
            exp_di = (i < 5) ? 6'h00 : (i < 7) ? 6'h12 : 6'h16;
            chk($sformatf("sim%0d_di", i), int'(di), int'(exp_di));
            chk($sformatf("sim%0d_chg", i), int'(chg), (i == 6 || i == 8) ? 1 : 0);
            if (chg) pulses++;
        end
        chk("sim_chg_count", pulses, 2);

        // Reset mid-count discards progress.
        tick(1, 0, 0); tick(1, 0, 0);
        tick(0, 6'h01, 0);
        tick(0, 6'h01, 0);
        tick(1, 6'h01, 0);
        chk("midrst_di", int'(di), 0);
        for (int j = 0; j < 7; j++) begin
            tick(0, 6'h01, 0);
            chk($sformatf("midrst%0d_di", j), int'(di), (j >= 5) ? 1 : 0);
        end

        // Randomized bouncing switches with occasional resets.
        rv = '0; iv = 0;
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, 5) == 0) rv[b] = ~rv[b];
            if ($urandom_range(0, 5) == 0) iv = ~iv;
            tick(($urandom_range(0, 199) == 0), rv, iv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
